// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: FSM states and the
// layout of one 24-bit program entry.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int          ENTRY_W    = 24;
  localparam logic [7:0]  NOP_OPCODE = 8'h00;

  localparam int OPC_HI = 23;
  localparam int OPC_LO = 16;
  localparam int A_HI   = 15;
  localparam int A_LO   = 8;
  localparam int B_HI   = 7;
  localparam int B_LO   = 0;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store: DEPTH x 24 register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side for the 8-bit opcode ALU: replays a loaded program one entry per
// clock onto the ALU inputs, then captures the ALU's z output as the result.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [23:0]   prog_wdata_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [7:0]    alu_opcode_o,
  output logic [7:0]    alu_a_o,
  output logic [7:0]    alu_b_o,
  input  logic [7:0]    alu_z_i,
  output logic [7:0]    result_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    dbg_state_o
);

  localparam logic [AW:0] DEPTH_L = PROG_DEPTH[AW:0];
  localparam logic [AW:0] PC_ONE  = 1;

  state_e             state_q, state_d;
  logic [AW:0]        pc_q, pc_d, len_q, len_d, len_clamped;
  logic [7:0]         opc_q, opc_d, a_q, a_d, b_q, b_d, result_q, result_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]      rd_idx;
  logic [ENTRY_W-1:0] rd_entry;
  logic               start_ok, mem_we;

  // Host handshake: start and prog_we are single-cycle strobes honoured only
  // in IDLE; start beats prog_we in the same cycle, and abort beats start.
  assign start_ok    = start_i && !abort_i && (state_q == IDLE);
  assign mem_we      = prog_we_i && !start_i && (state_q == IDLE);
  assign len_clamped = (prog_len_i > DEPTH_L) ? DEPTH_L : prog_len_i;
  assign rd_idx      = (state_q == IDLE) ? '0 : pc_q[AW-1:0];

  alu_seq_prog_mem #(.DEPTH(PROG_DEPTH), .AW(AW)) u_prog_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_wdata_i),
    .raddr_i (rd_idx),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && (len_clamped != '0)) state_d = ISSUE;
      ISSUE:   if (abort_i) state_d = IDLE;
               else if (pc_q == len_q) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs fall back to a NOP (all-zero) whenever nothing is being issued.
  always_comb begin
    opc_d    = NOP_OPCODE;
    a_d      = 8'h00;
    b_d      = 8'h00;
    pc_d     = pc_q;
    len_d    = len_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (len_clamped != '0) begin
            len_d  = len_clamped;
            opc_d  = rd_entry[OPC_HI:OPC_LO];
            a_d    = rd_entry[A_HI:A_LO];
            b_d    = rd_entry[B_HI:B_LO];
            pc_d   = PC_ONE;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort_i) begin
          pc_d = '0;
        end else if (pc_q < len_q) begin
          opc_d  = rd_entry[OPC_HI:OPC_LO];
          a_d    = rd_entry[A_HI:A_LO];
          b_d    = rd_entry[B_HI:B_LO];
          pc_d   = pc_q + PC_ONE;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DRAIN: begin
        pc_d = '0;
        if (!abort_i) begin
          result_d = alu_z_i;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      len_q    <= '0;
      opc_q    <= NOP_OPCODE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      len_q    <= len_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign alu_opcode_o = opc_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign dbg_state_o  = state_q;

endmodule
